// File: rtl/pat_data_buffer_if.sv
// Pattern data buffer bus: load strobe, data, mode and step controls
// in; current pattern word, pixel field and FIFO status flags out.
interface pat_data_buffer_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int PIXW  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            LDPATL;
    logic [DW-1:0]   ID;
    logic            MODE;
    logic            PIXSTEP;
    logic            CLROVF;
    logic [DW-1:0]   PATD;
    logic [PIXW-1:0] PIX;
    logic            PVALID;
    logic            FULL;
    logic            EMPTY;
    logic [CW-1:0]   COUNT;
    logic            OVFL;

    modport master (
        output LDPATL, ID, MODE, PIXSTEP, CLROVF,
        input  PATD, PIX, PVALID, FULL, EMPTY, COUNT, OVFL
    );

    modport slave (
        input  LDPATL, ID, MODE, PIXSTEP, CLROVF,
        output PATD, PIX, PVALID, FULL, EMPTY, COUNT, OVFL
    );
endinterface

// File: rtl/pat_data_buffer.sv
// Pattern data buffer: static pattern register or DEPTH-entry prefetch
// FIFO feeding a current-word register that is serialised by PIXSTEP.
// Ports: MasterClock, RESET (sync, active high), bus (slave modport).
module pat_data_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int PIXW  = 4
) (
    input  logic             MasterClock,
    input  logic             RESET,
    pat_data_buffer_if.slave bus
);
    localparam int NPIX = DW / PIXW;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] patd, n_patd;
    logic [IW-1:0] idx, n_idx, idx_b;
    logic [PW-1:0] rd_ptr, wr_ptr, n_rd, n_wr, rd_b, wr_b;
    logic [CW-1:0] count, n_cnt, cnt_b;
    logic          pvalid, n_pv;
    logic          ovfl, n_ovfl;
    logic          mode_q;
    logic          flush, load, step, last;
    logic          direct, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // A mode change flushes the FIFO before this cycle's load is seen
        flush  = bus.MODE != mode_q;
        load   = !bus.LDPATL;
        cnt_b  = flush ? '0 : count;
        rd_b   = flush ? '0 : rd_ptr;
        wr_b   = flush ? '0 : wr_ptr;
        idx_b  = flush ? '0 : idx;
        n_patd = patd;
        n_pv   = pvalid;
        n_idx  = idx_b;
        n_cnt  = cnt_b;
        n_rd   = rd_b;
        n_wr   = wr_b;
        n_ovfl = bus.CLROVF ? 1'b0 : ovfl;
        step   = 1'b0;
        last   = 1'b0;
        direct = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        if (!bus.MODE) begin
            n_idx = '0;
            n_cnt = '0;
            n_rd  = '0;
            n_wr  = '0;
            if (load) begin
                n_patd = bus.ID;
                n_pv   = 1'b1;
            end
        end else begin
            step   = pvalid && bus.PIXSTEP;
            last   = step && (idx_b == IW'(NPIX - 1));
            direct = load && (cnt_b == '0) && (!pvalid || last);
            pop    = last && (cnt_b != '0);
            // A full FIFO still accepts a load when the same edge pops
            push   = load && !direct &&
                     ((cnt_b != CW'(DEPTH)) || pop);
            if (load && !direct && !push)
                n_ovfl = 1'b1;
            if (last)
                n_idx = '0;
            else if (step)
                n_idx = idx_b + IW'(1);
            if (pop) begin
                n_patd = mem[rd_b];
            end else if (direct) begin
                n_patd = bus.ID;
                n_pv   = 1'b1;
                n_idx  = '0;
            end else if (last) begin
                n_pv = 1'b0;
            end
            if (pop)
                n_rd = ptr_inc(rd_b);
            if (push)
                n_wr = ptr_inc(wr_b);
            n_cnt = cnt_b + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge MasterClock) begin
        if (RESET) begin
            patd   <= '0;
            idx    <= '0;
            pvalid <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            ovfl   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            patd   <= n_patd;
            idx    <= n_idx;
            pvalid <= n_pv;
            count  <= n_cnt;
            rd_ptr <= n_rd;
            wr_ptr <= n_wr;
            ovfl   <= n_ovfl;
            mode_q <= bus.MODE;
        end
    end

    // When full, wr_b equals rd_b: the popped word is read before
    // the pushed word overwrites that slot, which becomes the tail.
    always_ff @(posedge MasterClock) begin
        if (!RESET && push)
            mem[wr_b] <= bus.ID;
    end

    assign bus.PATD   = patd;
    assign bus.PIX    = patd[int'(idx) * PIXW +: PIXW];
    assign bus.PVALID = pvalid;
    assign bus.COUNT  = count;
    assign bus.FULL   = count == CW'(DEPTH);
    assign bus.EMPTY  = count == '0;
    assign bus.OVFL   = ovfl;
endmodule

// File: doc/pat_data_buffer.md
Name: pat_data_buffer

Overview:
- Parametrised successor to the 8-bit pattern data latch in the blitter datapath.
- Replaces a transparent latch with a clocked register. Adds a DEPTH-entry FIFO of pattern words and a pixel serialiser, so the blitter can prefetch pattern data and step through it pixel by pixel.
- A static mode keeps the legacy behaviour of a single pattern register on PATD.

Parameters:
- DW, 8, pattern word width in bits.
- DEPTH, 4, FIFO entries (≥1). The current-word register is not counted in DEPTH.
- PIXW, 4, pixel field width in bits. Must divide DW. NPIX = DW/PIXW.

Ports:
- MasterClock  input  1  system clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- LDPATL  input  1  active-low load strobe, sampled on clock edge.
- ID  input  DW  internal data bus, pattern word to load.
- MODE  input  1  0 = static register, 1 = stream/serialise.
- PIXSTEP  input  1  advance to next pixel (stream mode only).
- CLROVF  input  1  clear sticky overflow flag.
- PATD  output  DW  current pattern word.
- PIX  output  PIXW  current pixel field, PATD[idx*PIXW +: PIXW].
- PVALID  output  1  current word is valid.
- FULL  output  1  FIFO count == DEPTH.
- EMPTY  output  1  FIFO count == 0.
- COUNT  output  clog2(DEPTH+1)  FIFO occupancy.
- OVFL  output  1  sticky: a load was dropped.

Behaviour:

Reset:
- RESET=1 at a clock edge overrides every other input. Mid-operation reset discards all FIFO contents.
- After reset: PATD=0, idx=0, PVALID=0, COUNT=0, EMPTY=1, FULL=0, OVFL=0.

Static mode (MODE=0):
- LDPATL=0 writes ID into PATD at the next edge (1-cycle latency) and sets PVALID=1.
- PIXSTEP is ignored. idx is held at 0. The FIFO is unused and stays empty.

Stream mode (MODE=1), load:
- A load (LDPATL=0) goes straight into PATD, with idx=0 and PVALID=1, when either:
  - PVALID=0 and the FIFO is empty, or
  - the same cycle consumes the last pixel and the FIFO is empty.
- Otherwise the load is pushed into the FIFO.

Stream mode, PIXSTEP with PVALID=1:
- If idx < NPIX-1: idx increments.
- If idx = NPIX-1 (last pixel): idx becomes 0, and then:
  - FIFO non-empty: head word is popped into PATD.
  - FIFO empty, load present: PATD takes ID.
  - FIFO empty, no load: PVALID becomes 0 and PATD holds its old value.
- PIX presents pixels LSB field first.

Stream mode, other rules:
- PIXSTEP with PVALID=0 is ignored.
- Full FIFO with a pop in the same cycle: the load is accepted, COUNT is unchanged, and order is preserved.
- Full FIFO with no pop: the load is dropped, FIFO contents are unchanged, and OVFL is set.
- FIFO is strict first-in first-out. Pointers wrap modulo DEPTH.

Flags:
- OVFL is set at the edge following a dropped load.
- OVFL is cleared by CLROVF=1 or RESET. If set and clear occur in the same cycle, set wins.

Mode change:
- MODE is registered. Any cycle where MODE differs from its registered value flushes the FIFO (COUNT=0) and sets idx=0.
- PATD and PVALID are retained across a mode change.
- A load in that same cycle is handled by the new mode's rules after the flush.

General:
- FULL, EMPTY and COUNT are combinational from registered state; they reflect the state after the edge.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then MODE=0; LDPATL=0 with ID=0xA5 for one cycle → PATD=0xA5 and PVALID=1 next cycle. Apply PIXSTEP → PIX stays 0x5.
2. MODE=1; load 0x21, then 0x43 → PATD=0x21, COUNT=1, PIX=0x1. PIXSTEP → PIX=0x2. PIXSTEP → PATD=0x43, PIX=0x3, COUNT=0. PIXSTEP x2 → PVALID=0.
3. MODE=1, DEPTH=4; load 6 words with no PIXSTEP → PATD=word0, COUNT=4, FULL=1, word5 dropped, OVFL=1. Apply CLROVF → OVFL=0.
4. MODE=1, FIFO full, idx=NPIX-1; PIXSTEP and load 0x99 in the same cycle → pop and push both occur, COUNT stays 4, OVFL=0, and 0x99 emerges last.
5. MODE=1, PVALID=1, FIFO empty, idx=NPIX-1; PIXSTEP plus load 0x77 → PATD=0x77, idx=0, PVALID stays 1.
6. MODE=1 with COUNT=3; assert RESET for one cycle → all outputs at reset values next cycle. Separately, toggle MODE to 0 with COUNT=2 → COUNT=0 and PATD unchanged.
